flash_read_master: RTL and testbench

FLASH_READ_MASTER -- requirements
Module: flash_read_master

---
 rtl/flash_read_master_pkg.sv | 7 +
 rtl/flash_read_master.sv | 94 +++++++++
 tb/tb_flash_read_master.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/flash_read_master_pkg.sv
// flash_read_master_pkg: shared state encoding and sizes for the flash read path.
package flash_read_master_pkg;
  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, DONE, ERR} fr_state_e;
endpackage

// File: rtl/flash_read_master.sv
// flash_read_master: single-word Avalon-MM flash read with timeout abort.
module flash_read_master
  import flash_read_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int ADDR_W = FLASH_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_read,
  input  logic [23:0]             addr,
  output logic                    finish_read,
  output logic [FLASH_DATA_W-1:0] read32b_data_out,
  output logic                    busy,
  output logic                    error,
  output logic                    flash_mem_read,
  output logic [ADDR_W-1:0]       flash_mem_address,
  output logic [3:0]              flash_mem_byteenable,
  output logic [5:0]              flash_mem_burstcount,
  input  logic                    flash_mem_waitrequest,
  input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
  input  logic                    flash_mem_readdatavalid
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  fr_state_e state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [FLASH_DATA_W-1:0] data_nx;
  logic rd_nx, err_nx, timeout, got_data;
  logic unused_addr;
  assign unused_addr = ^addr[23:ADDR_W];
  assign flash_mem_byteenable = 4'hF;
  assign flash_mem_burstcount = 6'd1;
  assign timeout = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // data may ride along with the accepting cycle, so REQ can capture too
  assign got_data = flash_mem_readdatavalid &&
                    (state == WAIT_DATA || (state == REQ && !flash_mem_waitrequest));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      flash_mem_read <= 1'b0;
      flash_mem_address <= '0;
      read32b_data_out <= '0;
      error <= 1'b0;
      finish_read <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      flash_mem_read <= rd_nx;
      flash_mem_address <= addr_nx;
      read32b_data_out <= data_nx;
      error <= err_nx;
      finish_read <= state_nx inside {DONE, ERR};
      busy <= state_nx != IDLE;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    rd_nx = flash_mem_read;
    addr_nx = flash_mem_address;
    data_nx = read32b_data_out;
    err_nx = error;
    case (state)
      IDLE: if (start_read) begin
        state_nx = REQ;
        rd_nx = 1'b1;
        addr_nx = addr[ADDR_W-1:0];
        err_nx = 1'b0;
        cnt_nx = '0;
      end
      REQ, WAIT_DATA: begin
        cnt_nx = cnt + CNT_W'(1);
        if (state == REQ && !flash_mem_waitrequest) begin
          rd_nx = 1'b0;
          state_nx = WAIT_DATA;
        end
        // arriving data outranks a simultaneous timeout
        if (got_data) begin
          state_nx = DONE;
          rd_nx = 1'b0;
          data_nx = flash_mem_readdata;
        end else if (timeout) begin
          state_nx = ERR;
          rd_nx = 1'b0;
          data_nx = '0;
          err_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_flash_read_master.sv
// tb_flash_read_master: scoreboard bench with a reactive Avalon-MM slave model.
module tb_flash_read_master;
  localparam int TO = 8;
  logic clk = 0, reset = 0, start_read = 0;
  logic [23:0] addr = '0;
  logic finish_read, busy, error, flash_mem_read;
  logic [31:0] read32b_data_out;
  logic [22:0] flash_mem_address;
  logic [3:0] flash_mem_byteenable;
  logic [5:0] flash_mem_burstcount;
  logic flash_mem_waitrequest = 0, flash_mem_readdatavalid = 0;
  logic [31:0] flash_mem_readdata = '0;
  typedef struct packed {logic [31:0] data; logic err;} exp_t;
  exp_t sb_q[$];
  logic [22:0] addr_q[$];
  int n_chk = 0, n_fail = 0, stall_left = 0, mode = 0, accepts = 0;
  logic [31:0] rsp_data = '0;
  bit rdv_next = 0, late_rdv = 0, prev_fin = 0;

  flash_read_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start_read(start_read), .addr(addr),
    .finish_read(finish_read), .read32b_data_out(read32b_data_out),
    .busy(busy), .error(error), .flash_mem_read(flash_mem_read),
    .flash_mem_address(flash_mem_address),
    .flash_mem_byteenable(flash_mem_byteenable),
    .flash_mem_burstcount(flash_mem_burstcount),
    .flash_mem_waitrequest(flash_mem_waitrequest),
    .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave: mode 0 never returns data, 1 returns the cycle after accept, 2 with accept
  initial forever begin
    @(negedge clk);
    flash_mem_readdatavalid = 0;
    flash_mem_waitrequest = 0;
    if (rdv_next || late_rdv) begin
      flash_mem_readdatavalid = 1;
      flash_mem_readdata = rsp_data;
      rdv_next = 0;
      late_rdv = 0;
    end
    if (flash_mem_read && reset) begin
      if (stall_left > 0) begin
        flash_mem_waitrequest = 1;
        stall_left--;
        if (addr_q.size() > 0) check("addr_stable", flash_mem_address, addr_q[0]);
      end else begin
        accepts++;
        if (addr_q.size() == 0) check("addr_unexp", flash_mem_read, 0);
        else check("addr", flash_mem_address, addr_q.pop_front());
        if (mode == 2) begin
          flash_mem_readdatavalid = 1;
          flash_mem_readdata = rsp_data;
        end else if (mode == 1) rdv_next = 1;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (finish_read) begin
      check("busy_at_finish", busy, 1);
      check("finish_width", prev_fin, 0);
      if (sb_q.size() == 0) check("unexp_finish", finish_read, 0);
      else begin
        e = sb_q.pop_front();
        check("data", read32b_data_out, e.data);
        check("error", error, e.err);
      end
    end
    prev_fin = finish_read;
  end

  task automatic do_read(input logic [23:0] a, input logic [31:0] d, input int st,
                         input int md, input int lat_exp, input bit err, input bit dup);
    int lat;
    exp_t e;
    stall_left = st;
    mode = md;
    rsp_data = d;
    addr_q.push_back(a[22:0]);
    e.data = err ? 32'h0 : d;
    e.err = err;
    sb_q.push_back(e);
    @(negedge clk);
    start_read = 1;
    addr = a;
    @(negedge clk);
    start_read = dup;
    addr = dup ? 24'h7FFFF0 : a;
    lat = 1;
    check("busy_start", busy, 1);
    check("error_clear", error, 0);
    while (!finish_read && lat < 40) begin
      @(negedge clk);
      start_read = 0;
      lat++;
    end
    check("latency", lat, lat_exp);
  endtask

  initial begin
    int a0;
    #12;
    check("rst_read", flash_mem_read, 0);
    check("rst_addr", flash_mem_address, 0);
    check("rst_data", read32b_data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish_read, 0);
    check("rst_error", error, 0);
    check("byteenable", flash_mem_byteenable, 4'hF);
    check("burstcount", flash_mem_burstcount, 6'd1);
    @(negedge clk);
    reset = 1;
    do_read(24'h000010, 32'h11223344, 0, 1, 3, 0, 0);
    do_read(24'h000100, 32'hCAFEF00D, 0, 2, 2, 0, 0);
    do_read(24'h000025, 32'hA5A55A5A, 5, 1, 8, 0, 0);
    do_read(24'h800040, 32'h0BADF00D, 6, 1, 9, 0, 0);
    do_read(24'h000055, 32'h99999999, 0, 0, 9, 1, 0);
    repeat (3) @(negedge clk);
    check("error_held", error, 1);
    check("err_data_held", read32b_data_out, 0);
    check("idle_busy", busy, 0);
    a0 = accepts;
    do_read(24'h000066, 32'h12345678, 3, 1, 6, 0, 1);
    repeat (4) @(negedge clk);
    check("single_accept", accepts - a0, 1);
    do_read(24'h000001, 32'h00001111, 0, 1, 3, 0, 0);
    do_read(24'h000002, 32'h00002222, 0, 1, 3, 0, 0);
    @(negedge clk);
    stall_left = 0;
    mode = 0;
    addr_q.push_back(23'h33);
    start_read = 1;
    addr = 24'h000033;
    @(negedge clk);
    start_read = 0;
    @(negedge clk);
    check("wait_read_low", flash_mem_read, 0);
    check("wait_busy", busy, 1);
    #1 reset = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", flash_mem_address, 0);
    @(negedge clk);
    reset = 1;
    rsp_data = 32'hDEADBEEF;
    late_rdv = 1;
    repeat (4) @(negedge clk);
    check("late_rdv_data", read32b_data_out, 0);
    check("late_rdv_busy", busy, 0);
    check("sb_empty", sb_q.size(), 0);
    check("addr_q_empty", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
